mem_port_arbiter: RTL and testbench

- Shares the single synchronous block-RAM port behind controller_alu_reg_mem_pc between three requesters:
  - the VGA glyph/sprite fetcher (read-only);
  - the CPU load/store path (read/write);
  - the piano-key IO writer (write-only).
- Two-state FSM, one memory access per two clocks.
- Fixed priority for VGA, with a starvation override for the CPU.
- Round-robin between CPU and IO.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter for a single synchronous block-RAM port (VGA read, CPU read/write, IO write).
// Two-state FSM: IDLE arbitrates and launches the access, ISSUE acknowledges it.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic              vga_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    input  logic              io_req,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // state | meaning
    // IDLE  | arbitrate; launch the winner's access onto mem_*
    // ISSUE | memory performs the access; winner sees its ack
    typedef enum logic {IDLE, ISSUE} state_t;

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
    localparam int G_VGA = 0;
    localparam int G_CPU = 1;
    localparam int G_IO  = 2;

    state_t            state_q, state_d;
    logic [2:0]        grant_q, grant_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [CW-1:0]     starve_q, starve_d;
    logic              rr_last_q, rr_last_d;   // 1 = IO won the last CPU/IO grant
    logic [2:0]        gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rvalid_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            starve_q    <= '0;
            rr_last_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rvalid_q    <= rvalid_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            starve_q    <= starve_d;
            rr_last_q   <= rr_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rvalid_d    = '0;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        starve_d    = starve_q;
        rr_last_d   = rr_last_q;
        gnt         = '0;

        case (state_q)
            IDLE: begin
                if (cpu_req && (starve_q >= STARVE_LIM)) gnt[G_CPU] = 1'b1;
                else if (vga_req)                        gnt[G_VGA] = 1'b1;
                else if (cpu_req && io_req) begin
                    if (rr_last_q) gnt[G_CPU] = 1'b1;
                    else           gnt[G_IO]  = 1'b1;
                end
                else if (cpu_req)                        gnt[G_CPU] = 1'b1;
                else if (io_req)                         gnt[G_IO]  = 1'b1;

                if (gnt != 3'b000) begin
                    state_d  = ISSUE;
                    grant_d  = gnt;
                    mem_en_d = 1'b1;
                end
                if (gnt[G_VGA]) begin
                    mem_we_d    = 1'b0;
                    mem_addr_d  = vga_addr;
                    mem_wdata_d = '0;
                end else if (gnt[G_CPU]) begin
                    mem_we_d    = cpu_we;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    rr_last_d   = 1'b0;
                end else if (gnt[G_IO]) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = io_addr;
                    mem_wdata_d = io_wdata;
                    rr_last_d   = 1'b1;
                end

                if (gnt[G_CPU])                            starve_d = '0;
                else if (cpu_req && (starve_q < STARVE_LIM)) starve_d = starve_q + CW'(1);
            end
            ISSUE: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                rvalid_d = {grant_q[G_CPU] && !mem_we_q, grant_q[G_VGA]};
            end
            default: state_d = IDLE;
        endcase
    end

    assign vga_ack    = (state_q == ISSUE) && grant_q[G_VGA];
    assign cpu_ack    = (state_q == ISSUE) && grant_q[G_CPU];
    assign io_ack     = (state_q == ISSUE) && grant_q[G_IO];
    assign vga_rvalid = rvalid_q[0];
    assign cpu_rvalid = rvalid_q[1];
    assign rdata      = mem_rdata;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural block-RAM and grant/read scoreboards.
module tb_mem_port_arbiter;

    localparam int VGA = 1;
    localparam int CPU = 2;
    localparam int IO  = 4;

    typedef struct {
        int          who;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } grant_t;

    typedef struct {
        int          who;
        logic [15:0] data;
    } read_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        vga_req, cpu_req, cpu_we, io_req;
    logic [15:0] vga_addr, cpu_addr, cpu_wdata, io_addr, io_wdata;
    logic        vga_ack, vga_rvalid, cpu_ack, cpu_rvalid, io_ack;
    logic [15:0] rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;
    logic [15:0] mem [0:255];

    int n_vec = 0;
    int n_err = 0;
    grant_t exp_g[$];
    read_t  exp_r[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack), .vga_rvalid(vga_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid),
        .io_req(io_req), .io_addr(io_addr), .io_wdata(io_wdata), .io_ack(io_ack),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    function automatic int who_ack();
        return (vga_ack ? VGA : 0) + (cpu_ack ? CPU : 0) + (io_ack ? IO : 0);
    endfunction

    function automatic int who_rv();
        return (vga_rvalid ? VGA : 0) + (cpu_rvalid ? CPU : 0);
    endfunction

    function automatic logic [53:0] out_vec();
        return {vga_ack, vga_rvalid, cpu_ack, cpu_rvalid, io_ack, mem_en, mem_we, mem_addr, mem_wdata, 1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    task automatic start_reset();
        reset = 1'b1;
        vga_req = 0; cpu_req = 0; cpu_we = 0; io_req = 0;
        vga_addr = '0; cpu_addr = '0; cpu_wdata = '0; io_addr = '0; io_wdata = '0;
        exp_g.delete();
        exp_r.delete();
        step();
        step();
    endtask

    task automatic test_reset();
        start_reset();
        n_vec++;
        if (out_vec() !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h want 0", out_vec());
        end
        reset = 1'b0;
        step();
        step();
        n_vec++;
        if (out_vec() !== '0) begin
            n_err++; $display("FAIL idle_no_req: got %h want 0", out_vec());
        end
    endtask

    task automatic test_cpu_load();
        read_t r;
        start_reset();
        preload(8'h10, 16'hBEEF);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        exp_r.push_back('{CPU, 16'hBEEF});
        reset = 1'b0;
        step();
        n_vec++;
        if ({mem_en, mem_we, cpu_ack, mem_addr} !== {1'b1, 1'b0, 1'b1, 16'h0010}) begin
            n_err++; $display("FAIL load_issue: got en/we/ack/addr %b%b%b/%h want 101/0010",
                              mem_en, mem_we, cpu_ack, mem_addr);
        end
        cpu_req = 0;
        step();
        r = exp_r.pop_front();
        n_vec++;
        if ({who_rv(), rdata} !== {r.who, r.data} || cpu_ack !== 1'b0) begin
            n_err++; $display("FAIL load_rvalid: got rv %0d rdata %h ack %b want rv %0d rdata %h ack 0",
                              who_rv(), rdata, cpu_ack, r.who, r.data);
        end
    endtask

    task automatic test_round_robin();
        grant_t e;
        int w;
        start_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
        io_req = 1; io_addr = 16'h0030; io_wdata = 16'h00AA;
        exp_g.push_back('{CPU, 1'b1, 16'h0020, 16'h1234});
        exp_g.push_back('{IO,  1'b1, 16'h0030, 16'h00AA});
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            w = who_ack();
            if (w != 0) begin
                n_vec++;
                if (exp_g.size() == 0) begin
                    n_err++; $display("FAIL rr_extra_grant: got ack %0d want none", w);
                end else begin
                    e = exp_g.pop_front();
                    if ({w, mem_we, mem_addr, mem_wdata} !== {e.who, e.we, e.addr, e.wdata}) begin
                        n_err++; $display("FAIL rr_grant: got who %0d we %b addr %h wd %h want %0d %b %h %h",
                                          w, mem_we, mem_addr, mem_wdata, e.who, e.we, e.addr, e.wdata);
                    end
                end
                if (w == CPU) cpu_req = 0;
                if (w == IO) io_req = 0;
            end
            n_vec++;
            if (who_rv() !== 0) begin
                n_err++; $display("FAIL rr_rvalid: got %0d want 0", who_rv());
            end
        end
        n_vec++;
        if (exp_g.size() !== 0) begin
            n_err++; $display("FAIL rr_missing_grants: got %0d left want 0", exp_g.size());
        end
        n_vec++;
        if ({mem[8'h20], mem[8'h30]} !== {16'h1234, 16'h00AA}) begin
            n_err++; $display("FAIL rr_mem: got %h %h want 1234 00aa", mem[8'h20], mem[8'h30]);
        end
    endtask

    task automatic test_starvation();
        grant_t e;
        read_t  r;
        int w, nacks;
        start_reset();
        preload(8'h40, 16'h4444);
        preload(8'h50, 16'h5555);
        vga_req = 1; vga_addr = 16'h0040;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0050;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) begin
                exp_g.push_back('{CPU, 1'b0, 16'h0050, 16'h0000});
                exp_r.push_back('{CPU, 16'h5555});
            end else begin
                exp_g.push_back('{VGA, 1'b0, 16'h0040, 16'h0000});
                exp_r.push_back('{VGA, 16'h4444});
            end
        end
        reset = 1'b0;
        nacks = 0;
        for (int c = 0; c < 24; c++) begin
            step();
            w = who_ack();
            if (w != 0) begin
                nacks++;
                n_vec++;
                if (exp_g.size() == 0) begin
                    n_err++; $display("FAIL starve_extra_grant: got ack %0d want none", w);
                end else begin
                    e = exp_g.pop_front();
                    if ({w, mem_we, mem_addr} !== {e.who, e.we, e.addr}) begin
                        n_err++; $display("FAIL starve_grant%0d: got who %0d we %b addr %h want %0d %b %h",
                                          nacks, w, mem_we, mem_addr, e.who, e.we, e.addr);
                    end
                end
                if (nacks == 10) begin
                    vga_req = 0; cpu_req = 0;
                end
            end
            if (who_rv() != 0) begin
                n_vec++;
                if (exp_r.size() == 0) begin
                    n_err++; $display("FAIL starve_extra_rvalid: got %0d want none", who_rv());
                end else begin
                    r = exp_r.pop_front();
                    if ({who_rv(), rdata} !== {r.who, r.data}) begin
                        n_err++; $display("FAIL starve_read: got who %0d rdata %h want %0d %h",
                                          who_rv(), rdata, r.who, r.data);
                    end
                end
            end
        end
        n_vec++;
        if (exp_g.size() + exp_r.size() !== 0) begin
            n_err++; $display("FAIL starve_missing: got %0d grants %0d reads left want 0 0",
                              exp_g.size(), exp_r.size());
        end
    endtask

    task automatic test_vga_io();
        grant_t e;
        read_t  r;
        int w, vga_c, rv_c, io_c;
        start_reset();
        preload(8'h60, 16'h6666);
        preload(8'h61, 16'h0000);
        vga_req = 1; vga_addr = 16'h0060;
        io_req = 1; io_addr = 16'h0061; io_wdata = 16'hA5A5;
        exp_g.push_back('{VGA, 1'b0, 16'h0060, 16'h0000});
        exp_g.push_back('{IO,  1'b1, 16'h0061, 16'hA5A5});
        exp_r.push_back('{VGA, 16'h6666});
        vga_c = -1; rv_c = -1; io_c = -1;
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            w = who_ack();
            n_vec++;
            if (mem_we !== (w == IO)) begin
                n_err++; $display("FAIL vi_mem_we: cycle %0d got %b want %b", c, mem_we, (w == IO));
            end
            if (w != 0) begin
                n_vec++;
                if (exp_g.size() == 0) begin
                    n_err++; $display("FAIL vi_extra_grant: got ack %0d want none", w);
                end else begin
                    e = exp_g.pop_front();
                    if ({w, mem_addr} !== {e.who, e.addr} || (e.we && mem_wdata !== e.wdata)) begin
                        n_err++; $display("FAIL vi_grant: got who %0d addr %h wd %h want %0d %h %h",
                                          w, mem_addr, mem_wdata, e.who, e.addr, e.wdata);
                    end
                end
                if (w == VGA) begin vga_req = 0; vga_c = c; end
                if (w == IO) begin io_req = 0; io_c = c; end
            end
            if (who_rv() != 0) begin
                rv_c = c;
                n_vec++;
                if (exp_r.size() == 0) begin
                    n_err++; $display("FAIL vi_extra_rvalid: got %0d want none", who_rv());
                end else begin
                    r = exp_r.pop_front();
                    if ({who_rv(), rdata} !== {r.who, r.data}) begin
                        n_err++; $display("FAIL vi_read: got who %0d rdata %h want %0d %h",
                                          who_rv(), rdata, r.who, r.data);
                    end
                end
            end
        end
        n_vec++;
        if (vga_c != 0 || rv_c != 1 || io_c != 2) begin
            n_err++; $display("FAIL vi_order: got vga/rv/io cycles %0d/%0d/%0d want 0/1/2", vga_c, rv_c, io_c);
        end
        n_vec++;
        if (mem[8'h61] !== 16'hA5A5) begin
            n_err++; $display("FAIL vi_mem: got %h want a5a5", mem[8'h61]);
        end
    endtask

    task automatic test_reset_in_issue();
        start_reset();
        preload(8'h18, 16'h1818);
        preload(8'h19, 16'h0000);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0018;
        reset = 1'b0;
        step();
        n_vec++;
        if (cpu_ack !== 1'b1) begin
            n_err++; $display("FAIL ri_ack: got %b want 1", cpu_ack);
        end
        reset = 1'b1;
        cpu_req = 0;
        step();
        n_vec++;
        if (out_vec() !== '0) begin
            n_err++; $display("FAIL ri_outputs: got %h want 0", out_vec());
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_vec++;
            if (out_vec() !== '0) begin
                n_err++; $display("FAIL ri_quiet%0d: got %h want 0", c, out_vec());
            end
        end
        io_req = 1; io_addr = 16'h0019; io_wdata = 16'h0909;
        step();
        n_vec++;
        if (who_ack() !== IO) begin
            n_err++; $display("FAIL ri_idle_grant: got ack %0d want %0d", who_ack(), IO);
        end
        io_req = 0;
        step();
        n_vec++;
        if (mem[8'h19] !== 16'h0909) begin
            n_err++; $display("FAIL ri_mem: got %h want 0909", mem[8'h19]);
        end
    endtask

    task automatic test_io_pulse();
        start_reset();
        preload(8'h70, 16'h0123);
        preload(8'h71, 16'h7171);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0071;
        reset = 1'b0;
        step();
        n_vec++;
        if (who_ack() !== CPU) begin
            n_err++; $display("FAIL ip_cpu_ack: got %0d want %0d", who_ack(), CPU);
        end
        cpu_req = 0;
        io_req = 1; io_addr = 16'h0070; io_wdata = 16'h7777;
        step();
        io_req = 0;
        n_vec++;
        if ({io_ack, cpu_rvalid, rdata} !== {1'b0, 1'b1, 16'h7171}) begin
            n_err++; $display("FAIL ip_rvalid: got io_ack %b rv %b rdata %h want 0 1 7171",
                              io_ack, cpu_rvalid, rdata);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            n_vec++;
            if ({io_ack, mem_en} !== 2'b00) begin
                n_err++; $display("FAIL ip_quiet%0d: got io_ack %b mem_en %b want 0 0", c, io_ack, mem_en);
            end
        end
        n_vec++;
        if (mem[8'h70] !== 16'h0123) begin
            n_err++; $display("FAIL ip_mem: got %h want 0123", mem[8'h70]);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_load();
        test_round_robin();
        test_starvation();
        test_vga_io();
        test_reset_in_issue();
        test_io_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
